// File: rtl/trap_seq_ctrl.sv
// Trap/return sequencer between the commit stage and the machine-mode CSR file.
// Picks one commit-boundary event by priority (timer irq > ecall > ebreak > mret),
// then runs flush -> CSR update strobe -> PC redirect. All outputs are registered.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | commits retire normally; events sampled at the commit boundary
// FLUSH    | flush_req high, waiting for flush_ack or the timeout
// UPDATE   | one-cycle csr_trap_we / csr_mret_we strobe
// REDIRECT | redirect_valid high with a stable target until redirect_ready
module trap_seq_ctrl #(
    parameter int XLEN          = 64,
    parameter int FLUSH_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_valid,
    input  logic [XLEN-1:0]  commit_pc,
    input  logic             commit_ecall,
    input  logic             commit_ebreak,
    input  logic             commit_mret,
    input  logic             mstatus_mie,
    input  logic             mie_mtie,
    input  logic             clint_mtip,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mepc,
    output logic             commit_stall,
    output logic             commit_retire,
    output logic             flush_req,
    input  logic             flush_ack,
    output logic             csr_trap_we,
    output logic             csr_mret_we,
    output logic [XLEN-1:0]  csr_cause,
    output logic [XLEN-1:0]  csr_epc,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic             timeout_err,
    output logic [CNT_W-1:0] trap_cnt
);

    typedef enum logic [1:0] {IDLE, FLUSH, UPDATE, REDIRECT} state_t;

    localparam int TMO_W = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(FLUSH_TIMEOUT - 1);
    localparam logic [XLEN-1:0] CAUSE_MTI    = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(7);
    localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
    localparam logic [XLEN-1:0] MTI_VEC_OFS  = XLEN'(28);

    state_t            state;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [XLEN-1:0]   lat_cause;
    logic [XLEN-1:0]   lat_epc;
    logic [XLEN-1:0]   lat_target;
    logic              lat_irq;
    logic              lat_mret;
    logic              irq_pend;
    logic [XLEN-1:0]   trap_vec;

    assign irq_pend = clint_mtip & mstatus_mie & mie_mtie;

    // Trap handler address: vectored mode only offsets interrupts (mtvec + 4*cause).
    always_comb begin
        trap_vec = mtvec & ~XLEN'(3);
        if (mtvec[1:0] == 2'b01 && lat_irq) begin
            trap_vec = (mtvec & ~XLEN'(3)) + MTI_VEC_OFS;
        end
    end

    // Sequencer FSM with registered handshake and strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            lat_cause      <= '0;
            lat_epc        <= '0;
            lat_target     <= '0;
            lat_irq        <= 1'b0;
            lat_mret       <= 1'b0;
            commit_stall   <= 1'b0;
            commit_retire  <= 1'b0;
            flush_req      <= 1'b0;
            csr_trap_we    <= 1'b0;
            csr_mret_we    <= 1'b0;
            csr_cause      <= '0;
            csr_epc        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            timeout_err    <= 1'b0;
            trap_cnt       <= '0;
        end else begin
            commit_retire <= 1'b0;
            csr_trap_we   <= 1'b0;
            csr_mret_we   <= 1'b0;
            csr_cause     <= '0;
            csr_epc       <= '0;
            case (state)
                IDLE: begin
                    if (commit_valid) begin
                        lat_irq    <= 1'b0;
                        lat_mret   <= 1'b0;
                        lat_cause  <= '0;
                        lat_epc    <= commit_pc;
                        lat_target <= '0;
                        if (irq_pend || commit_ecall || commit_ebreak || commit_mret) begin
                            state        <= FLUSH;
                            flush_req    <= 1'b1;
                            commit_stall <= 1'b1;
                            tmo_cnt      <= TMO_LOAD;
                        end
                        if (irq_pend) begin
                            lat_irq   <= 1'b1;
                            lat_cause <= CAUSE_MTI;
                        end else begin
                            commit_retire <= 1'b1;
                            if (commit_ecall) begin
                                lat_cause <= CAUSE_ECALL;
                            end else if (commit_ebreak) begin
                                lat_cause <= CAUSE_EBREAK;
                            end else if (commit_mret) begin
                                lat_mret   <= 1'b1;
                                lat_epc    <= '0;
                                lat_target <= mepc;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (flush_ack || tmo_cnt == '0) begin
                        if (!flush_ack) begin
                            timeout_err <= 1'b1;
                        end
                        state       <= UPDATE;
                        flush_req   <= 1'b0;
                        csr_trap_we <= ~lat_mret;
                        csr_mret_we <= lat_mret;
                        csr_cause   <= lat_cause;
                        csr_epc     <= lat_epc;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                UPDATE: begin
                    state          <= REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= lat_mret ? lat_target : trap_vec;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        redirect_pc    <= '0;
                        commit_stall   <= 1'b0;
                        trap_cnt       <= trap_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Testbench for trap_seq_ctrl: directed scenarios plus randomized sequences
// checked against a transaction-level model of the trap/return rules.
module tb_trap_seq_ctrl;

    localparam int XLEN  = 64;
    localparam int FT    = 16;
    localparam int CNT_W = 32;
    localparam logic [63:0] CAUSE_IRQ = 64'h8000_0000_0000_0007;

    logic             clk = 1'b0;
    logic             rst;
    logic             commit_valid;
    logic [XLEN-1:0]  commit_pc;
    logic             commit_ecall, commit_ebreak, commit_mret;
    logic             mstatus_mie, mie_mtie, clint_mtip;
    logic [XLEN-1:0]  mtvec, mepc;
    logic             commit_stall, commit_retire, flush_req, flush_ack;
    logic             csr_trap_we, csr_mret_we;
    logic [XLEN-1:0]  csr_cause, csr_epc;
    logic             redirect_valid, redirect_ready;
    logic [XLEN-1:0]  redirect_pc;
    logic             timeout_err;
    logic [CNT_W-1:0] trap_cnt;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_to;

    trap_seq_ctrl #(.XLEN(XLEN), .FLUSH_TIMEOUT(FT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_ecall(commit_ecall), .commit_ebreak(commit_ebreak), .commit_mret(commit_mret),
        .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie), .clint_mtip(clint_mtip),
        .mtvec(mtvec), .mepc(mepc),
        .commit_stall(commit_stall), .commit_retire(commit_retire),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .csr_trap_we(csr_trap_we), .csr_mret_we(csr_mret_we),
        .csr_cause(csr_cause), .csr_epc(csr_epc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
        .timeout_err(timeout_err), .trap_cnt(trap_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        commit_valid = 0; commit_pc = '0; commit_ecall = 0; commit_ebreak = 0; commit_mret = 0;
        mstatus_mie = 0; mie_mtie = 0; clint_mtip = 0; mtvec = '0; mepc = '0;
        flush_ack = 0; redirect_ready = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        clear_inputs();
        commit_valid = 1;
        commit_ecall = 1;
        repeat (2) tick();
        n_checks++; if ({commit_stall, commit_retire, flush_req, csr_trap_we, csr_mret_we, redirect_valid, timeout_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {commit_stall, commit_retire, flush_req, csr_trap_we, csr_mret_we, redirect_valid, timeout_err}); end
        n_checks++; if (csr_cause !== 64'd0 || csr_epc !== 64'd0) begin
            n_fail++; $display("FAIL reset_csr: got cause %h epc %h want 0", csr_cause, csr_epc); end
        n_checks++; if (redirect_pc !== 64'd0) begin
            n_fail++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        n_checks++; if (trap_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_trap_cnt: got %0d want 0", trap_cnt); end
        clear_inputs();
        rst = 0;
        tick();
        exp_cnt = 0;
        exp_to = 0;
    endtask

    task automatic test_ecall;
        clear_inputs();
        commit_valid = 1; commit_pc = 64'h8000_0010; commit_ecall = 1;
        mtvec = 64'h8000_0100; flush_ack = 1; redirect_ready = 1;
        tick();
        commit_valid = 0; commit_ecall = 0;
        n_checks++; if ({commit_retire, commit_stall, flush_req} !== 3'b111) begin
            n_fail++; $display("FAIL ecall_flush: got retire/stall/flush %b want 111", {commit_retire, commit_stall, flush_req}); end
        tick();
        n_checks++; if (csr_trap_we !== 1'b1 || csr_cause !== 64'd11 || csr_epc !== 64'h8000_0010 || commit_retire !== 1'b0) begin
            n_fail++; $display("FAIL ecall_update: got we %b cause %h epc %h retire %b want 1 11 80000010 0", csr_trap_we, csr_cause, csr_epc, commit_retire); end
        tick();
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100 || csr_trap_we !== 1'b0) begin
            n_fail++; $display("FAIL ecall_redirect: got valid %b pc %h we %b want 1 80000100 0", redirect_valid, redirect_pc, csr_trap_we); end
        tick();
        exp_cnt++;
        n_checks++; if (commit_stall !== 1'b0 || redirect_valid !== 1'b0 || trap_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL ecall_idle: got stall %b valid %b cnt %0d want 0 0 %0d", commit_stall, redirect_valid, trap_cnt, exp_cnt); end
    endtask

    task automatic test_irq_priority;
        clear_inputs();
        clint_mtip = 1; mstatus_mie = 1; mie_mtie = 1;
        commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0020;
        mtvec = 64'h8000_0101; flush_ack = 1; redirect_ready = 1;
        tick();
        commit_valid = 0; commit_ecall = 0;
        n_checks++; if (commit_retire !== 1'b0 || flush_req !== 1'b1) begin
            n_fail++; $display("FAIL irq_no_retire: got retire %b flush %b want 0 1", commit_retire, flush_req); end
        tick();
        n_checks++; if (csr_trap_we !== 1'b1 || csr_cause !== CAUSE_IRQ || csr_epc !== 64'h8000_0020) begin
            n_fail++; $display("FAIL irq_update: got we %b cause %h epc %h want 1 %h 80000020", csr_trap_we, csr_cause, csr_epc, CAUSE_IRQ); end
        tick();
        n_checks++; if (redirect_pc !== 64'h8000_011C) begin
            n_fail++; $display("FAIL irq_vector: got %h want 8000011c", redirect_pc); end
        tick();
        exp_cnt++;
        tick();
        tick();
        n_checks++; if (commit_stall !== 1'b0 || flush_req !== 1'b0 || trap_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL irq_no_commit_idle: got stall %b flush %b cnt %0d want 0 0 %0d", commit_stall, flush_req, trap_cnt, exp_cnt); end
    endtask

    task automatic test_mret_hold;
        int bad;
        clear_inputs();
        commit_valid = 1; commit_mret = 1; mepc = 64'h8000_0040; mtvec = 64'h8000_0100;
        flush_ack = 1; redirect_ready = 0;
        tick();
        commit_valid = 0; commit_mret = 0; mepc = 64'h1234_5678;
        n_checks++; if (commit_retire !== 1'b1) begin
            n_fail++; $display("FAIL mret_retire: got %b want 1", commit_retire); end
        tick();
        n_checks++; if (csr_mret_we !== 1'b1 || csr_trap_we !== 1'b0 || csr_cause !== 64'd0 || csr_epc !== 64'd0) begin
            n_fail++; $display("FAIL mret_update: got mret_we %b trap_we %b cause %h epc %h want 1 0 0 0", csr_mret_we, csr_trap_we, csr_cause, csr_epc); end
        tick();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0040 || commit_stall !== 1'b1 || csr_mret_we !== 1'b0) bad++;
            redirect_ready = (i == 5);
            tick();
        end
        n_checks++; if (bad != 0) begin
            n_fail++; $display("FAIL mret_redirect_hold: got %0d bad cycles of 6 want 0 (pc %h)", bad, redirect_pc); end
        exp_cnt++;
        n_checks++; if (redirect_valid !== 1'b0 || commit_stall !== 1'b0 || trap_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL mret_done: got valid %b stall %b cnt %0d want 0 0 %0d", redirect_valid, commit_stall, trap_cnt, exp_cnt); end
    endtask

    task automatic test_timeout;
        int nf;
        clear_inputs();
        commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0080; mtvec = 64'h8000_0200;
        redirect_ready = 1;
        tick();
        commit_valid = 0; commit_ecall = 0;
        n_checks++; if (timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
        nf = 0;
        while (flush_req === 1'b1 && nf < 40) begin
            nf++;
            tick();
        end
        n_checks++; if (nf != FT) begin
            n_fail++; $display("FAIL timeout_flush_cycles: got %0d want %0d", nf, FT); end
        n_checks++; if (timeout_err !== 1'b1 || csr_trap_we !== 1'b1) begin
            n_fail++; $display("FAIL timeout_update: got err %b trap_we %b want 1 1", timeout_err, csr_trap_we); end
        tick();
        tick();
        exp_cnt++;
        exp_to = 1;
        commit_valid = 1; commit_ebreak = 1; commit_pc = 64'h8000_0090; flush_ack = 1;
        tick();
        commit_valid = 0; commit_ebreak = 0;
        repeat (3) tick();
        exp_cnt++;
        n_checks++; if (timeout_err !== 1'b1 || trap_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL timeout_sticky: got err %b cnt %0d want 1 %0d", timeout_err, trap_cnt, exp_cnt); end
    endtask

    task automatic test_async_reset;
        clear_inputs();
        commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_00A0; mtvec = 64'h8000_0300;
        flush_ack = 1;
        tick();
        commit_valid = 0; commit_ecall = 0;
        tick();
        tick();
        n_checks++; if (redirect_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got redirect_valid %b want 1", redirect_valid); end
        #2 rst = 1;
        #1;
        n_checks++; if ({commit_stall, commit_retire, flush_req, csr_trap_we, csr_mret_we, redirect_valid, timeout_err} !== 7'b0
                        || redirect_pc !== 64'd0 || trap_cnt !== 32'd0) begin
            n_fail++; $display("FAIL areset_outputs: got ctrl %b pc %h cnt %0d want 0", {commit_stall, commit_retire, flush_req, csr_trap_we, csr_mret_we, redirect_valid, timeout_err}, redirect_pc, trap_cnt); end
        tick();
        rst = 0;
        exp_cnt = 0;
        exp_to = 0;
        tick();
        commit_valid = 1; commit_ebreak = 1; commit_pc = 64'h8000_00B0; mtvec = 64'h8000_0400;
        flush_ack = 1; redirect_ready = 1;
        tick();
        commit_valid = 0; commit_ebreak = 0;
        tick();
        n_checks++; if (csr_trap_we !== 1'b1 || csr_cause !== 64'd3 || csr_epc !== 64'h8000_00B0) begin
            n_fail++; $display("FAIL areset_ebreak: got we %b cause %h epc %h want 1 3 800000b0", csr_trap_we, csr_cause, csr_epc); end
        tick();
        tick();
        exp_cnt++;
        n_checks++; if (trap_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL areset_cnt: got %0d want %0d", trap_cnt, exp_cnt); end
    endtask

    task automatic test_irq_masked;
        int bad;
        clear_inputs();
        clint_mtip = 1; mie_mtie = 1; mstatus_mie = 0;
        commit_valid = 1; flush_ack = 1; redirect_ready = 1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            commit_pc = 64'h8000_1000 + 64'(4 * i);
            tick();
            if (commit_retire !== 1'b1 || commit_stall !== 1'b0 || flush_req !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin
            n_fail++; $display("FAIL masked_retire: got %0d bad cycles of 8 want 0", bad); end
        commit_valid = 0; mstatus_mie = 1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (commit_retire !== 1'b0 || flush_req !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0 || trap_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL masked_no_trap: got %0d bad cycles cnt %0d want 0 %0d", bad, trap_cnt, exp_cnt); end
    endtask

    task automatic test_random;
        logic        cv, ec, eb, mr, tip, mieb, tie, irq, is_evt, is_mret, exp_ret;
        logic [63:0] pc, mtv, mep, ecause, eepc, etgt;
        int          fdly, rdly, fcyc;
        for (int it = 0; it < 200; it++) begin
            cv   = ($urandom_range(0, 3) != 0);
            ec   = ($urandom_range(0, 2) == 0);
            eb   = ($urandom_range(0, 2) == 0);
            mr   = ($urandom_range(0, 2) == 0);
            tip  = ($urandom_range(0, 1) == 1);
            mieb = ($urandom_range(0, 1) == 1);
            tie  = ($urandom_range(0, 1) == 1);
            pc   = {$urandom, $urandom} & ~64'd3;
            mtv  = {$urandom, $urandom};
            mep  = {$urandom, $urandom};
            if (it % 10 == 0) begin
                cv = 1; tip = 1; mieb = 1; tie = 1;
                mtv = 64'hFFFF_FFFF_FFFF_FFF1;
            end
            fdly = $urandom_range(0, 19);
            if (fdly == FT - 1) fdly = FT;
            rdly = $urandom_range(0, 4);

            irq     = tip & mieb & tie;
            is_evt  = cv && (irq || ec || eb || mr);
            exp_ret = cv && !irq;
            is_mret = cv && !irq && !ec && !eb && mr;
            ecause  = irq ? ((64'd1 << 63) | 64'd7) : ec ? 64'd11 : eb ? 64'd3 : 64'd0;
            eepc    = is_mret ? 64'd0 : pc;
            if (is_mret) etgt = mep;
            else if (irq && mtv[1:0] == 2'b01) etgt = (mtv & ~64'd3) + 64'd28;
            else etgt = mtv & ~64'd3;
            fcyc = (fdly >= FT) ? FT : fdly + 1;

            commit_valid = cv; commit_pc = pc; commit_ecall = ec; commit_ebreak = eb; commit_mret = mr;
            clint_mtip = tip; mstatus_mie = mieb; mie_mtie = tie; mtvec = mtv; mepc = mep;
            flush_ack = ($urandom_range(0, 1) == 1);
            redirect_ready = ($urandom_range(0, 1) == 1);
            tick();

            if (!is_evt) begin
                n_checks++; if (commit_retire !== exp_ret || commit_stall !== 1'b0 || flush_req !== 1'b0 || trap_cnt !== exp_cnt) begin
                    n_fail++; $display("FAIL rnd_plain[%0d]: got retire %b stall %b flush %b cnt %0d want %b 0 0 %0d", it, commit_retire, commit_stall, flush_req, trap_cnt, exp_ret, exp_cnt); end
                continue;
            end
            if (fdly >= FT) exp_to = 1;

            commit_valid = ($urandom_range(0, 1) == 1);
            commit_ecall = ($urandom_range(0, 1) == 1);
            clint_mtip = 1; mstatus_mie = 1; mie_mtie = 1;
            mepc = {$urandom, $urandom};
            for (int k = 0; k < fcyc; k++) begin
                n_checks++; if (flush_req !== 1'b1 || commit_stall !== 1'b1 || commit_retire !== ((k == 0) ? exp_ret : 1'b0)) begin
                    n_fail++; $display("FAIL rnd_flush[%0d.%0d]: got flush %b stall %b retire %b want 1 1 %b", it, k, flush_req, commit_stall, commit_retire, (k == 0) ? exp_ret : 1'b0); end
                flush_ack = (k == fdly);
                redirect_ready = ($urandom_range(0, 1) == 1);
                tick();
            end
            n_checks++; if (csr_trap_we !== !is_mret || csr_mret_we !== is_mret || csr_cause !== ecause || csr_epc !== eepc
                            || flush_req !== 1'b0 || timeout_err !== exp_to) begin
                n_fail++; $display("FAIL rnd_update[%0d]: got tw %b mw %b cause %h epc %h flush %b to %b want %b %b %h %h 0 %b",
                                   it, csr_trap_we, csr_mret_we, csr_cause, csr_epc, flush_req, timeout_err, !is_mret, is_mret, ecause, eepc, exp_to); end
            flush_ack = ($urandom_range(0, 1) == 1);
            redirect_ready = ($urandom_range(0, 1) == 1);
            tick();
            for (int j = 0; j <= rdly; j++) begin
                n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== etgt || csr_trap_we !== 1'b0 || csr_mret_we !== 1'b0 || commit_stall !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_redirect[%0d.%0d]: got valid %b pc %h tw %b mw %b stall %b want 1 %h 0 0 1", it, j, redirect_valid, redirect_pc, csr_trap_we, csr_mret_we, commit_stall, etgt); end
                redirect_ready = (j == rdly);
                flush_ack = ($urandom_range(0, 1) == 1);
                tick();
            end
            exp_cnt++;
            n_checks++; if (commit_stall !== 1'b0 || redirect_valid !== 1'b0 || trap_cnt !== exp_cnt || timeout_err !== exp_to) begin
                n_fail++; $display("FAIL rnd_done[%0d]: got stall %b valid %b cnt %0d to %b want 0 0 %0d %b", it, commit_stall, redirect_valid, trap_cnt, timeout_err, exp_cnt, exp_to); end
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_irq_priority();
        test_mret_hold();
        test_timeout();
        test_async_reset();
        test_irq_masked();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_seq_ctrl.md
Name: trap_seq_ctrl

Overview:
Trap/return sequencer between the commit stage and the machine-mode CSR file. It samples commit-boundary events (ecall, ebreak, mret, timer interrupt) and picks one by priority. It then runs a pipeline flush handshake, issues a single-cycle CSR update strobe with cause/epc, and drives the PC redirect handshake. It owns trap ordering; the CSR file only executes the strobes it receives.

Parameters:
XLEN, 64, data/address width (matches DATA_BUS / INST_ADDR_BUS)
FLUSH_TIMEOUT, 16, max cycles in FLUSH waiting for flush_ack before the timeout error is raised
CNT_W, 32, width of the trap event counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
commit_valid  input  1  an instruction is at the commit boundary
commit_pc  input  XLEN  PC of the committing instruction
commit_ecall  input  1  committing instruction is ecall
commit_ebreak  input  1  committing instruction is ebreak
commit_mret  input  1  committing instruction is mret
mstatus_mie  input  1  mstatus[3] from the CSR file
mie_mtie  input  1  mie[7] from the CSR file
clint_mtip  input  1  timer interrupt level from CLINT
mtvec  input  XLEN  current mtvec
mepc  input  XLEN  current mepc
commit_stall  output  1  holds the commit stage while the sequence runs
commit_retire  output  1  1-cycle pulse: the committing instruction retires (minstret increment)
flush_req  output  1  pipeline flush request
flush_ack  input  1  pipeline flush complete
csr_trap_we  output  1  1-cycle strobe: write mepc/mcause, MPIE<=MIE, MIE<=0
csr_mret_we  output  1  1-cycle strobe: MIE<=MPIE, MPIE<=1
csr_cause  output  XLEN  mcause value; valid with csr_trap_we
csr_epc  output  XLEN  mepc value; valid with csr_trap_we
redirect_valid  output  1  redirect PC valid
redirect_pc  output  XLEN  redirect target
redirect_ready  input  1  fetch accepts the redirect
timeout_err  output  1  sticky flush-timeout flag
trap_cnt  output  CNT_W  count of completed trap and mret sequences

Behaviour:
- Reset (async, any state): FSM returns to IDLE. Every output is 0, including trap_cnt and timeout_err. Latched cause/epc/target are cleared.
- States: IDLE, FLUSH, UPDATE, REDIRECT.
- irq_pend = clint_mtip & mstatus_mie & mie_mtie, evaluated combinationally in IDLE.
- IDLE with commit_valid, in priority order:
  - irq_pend: take interrupt. cause = (1<<(XLEN-1)) | 7; epc = commit_pc; no retire.
  - ecall: cause = 11; epc = commit_pc; commit_retire pulses.
  - ebreak: cause = 3; epc = commit_pc; commit_retire pulses.
  - mret: mret sequence; target = mepc sampled this cycle; commit_retire pulses.
  - none of these: commit_retire = 1, commit_stall = 0, stay in IDLE.
- On any event: latch cause/epc/target, go to FLUSH. commit_stall goes high the next cycle and stays high through REDIRECT.
- Without commit_valid nothing is taken, even with irq_pend high.
- FLUSH:
  - flush_req = 1.
  - On the edge where flush_ack = 1, go to UPDATE.
  - A wait counter increments each FLUSH cycle. When it reaches FLUSH_TIMEOUT, set timeout_err (sticky until reset) and go to UPDATE anyway.
- UPDATE (exactly 1 cycle):
  - Trap path: csr_trap_we = 1 with csr_cause/csr_epc. redirect target = mtvec & ~3. If mtvec[1:0] == 01 and the trap is an interrupt, target = (mtvec & ~3) + 4*7.
  - mret path: csr_mret_we = 1; csr_cause and csr_epc stay 0.
  - Always go to REDIRECT.
- REDIRECT:
  - redirect_valid = 1; redirect_pc is held stable until accepted.
  - On the edge where redirect_ready = 1: trap_cnt += 1 (wraps at 2^CNT_W), go to IDLE, deassert commit_stall.
- Minimum sequence length is 3 cycles (FLUSH, UPDATE, REDIRECT with same-cycle acks).
- flush_ack or redirect_ready high outside their own state is ignored.
- An irq that arrives during a sequence is not taken. It is re-evaluated in IDLE; MIE is already 0 after a trap.
- XLEN arithmetic is unsigned; mtvec + 28 wraps modulo 2^XLEN.

Test Plan:
- Ecall at commit_pc = 0x8000_0010, mtvec = 0x8000_0100, both acks tied high -> commit_retire pulse; csr_trap_we with cause = 11, epc = 0x8000_0010; redirect_pc = 0x8000_0100; trap_cnt = 1; back in IDLE 3 cycles after FLUSH entry.
- mtip = mie = mtie = 1, ecall also set, pc = 0x8000_0020, mtvec = 0x8000_0101 -> interrupt wins; cause = 0x8000_0000_0000_0007; epc = 0x8000_0020; no retire; redirect_pc = 0x8000_011C.
- mret with mepc = 0x8000_0040, redirect_ready held low for 5 cycles -> csr_mret_we for 1 cycle; redirect_valid held with pc 0x8000_0040 for 6 cycles; commit_stall high throughout.
- flush_ack never asserted, FLUSH_TIMEOUT = 16 -> 16 cycles of flush_req; timeout_err = 1; UPDATE follows; flag stays set after a later normal trap.
- rst asserted asynchronously mid-REDIRECT -> all outputs 0 immediately without a clock edge; trap_cnt = 0; next ebreak gives cause = 3.
- clint_mtip = 1 with mstatus_mie = 0, plain instructions committing -> no trap; commit_retire every commit cycle; trap_cnt unchanged.
